// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with busy/done handshake
module booth_mult_seq #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               srst,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               op_signed,
    input  logic               op_ld,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] mult_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH:0]     m_reg;
    logic [WIDTH:0]     q_reg;
    logic [WIDTH+1:0]   a_reg;
    logic               q_1;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH+1:0]   m_ext;
    logic [WIDTH+1:0]   a_sum;
    logic [WIDTH+1:0]   a_nxt;
    logic [WIDTH:0]     q_nxt;
    logic [WIDTH:0]     opa_ext;
    logic [WIDTH:0]     opb_ext;
    logic               last_iter;

    // Operands are widened by one bit so unsigned values become non-negative
    // signed numbers; the Booth recoding then handles both modes identically.
    assign opa_ext   = {op_signed & opa[WIDTH-1], opa};
    assign opb_ext   = {op_signed & opb[WIDTH-1], opb};
    assign m_ext     = {m_reg[WIDTH], m_reg};
    assign last_iter = (cnt == CNT_W'(WIDTH));

    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_1})
            2'b01:   a_sum = a_reg + m_ext;
            2'b10:   a_sum = a_reg - m_ext;
            default: a_sum = a_reg;
        endcase
    end

    // Arithmetic right shift of {A, Q, q_1}; q_1 takes the old Q[0].
    assign a_nxt = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
    assign q_nxt = {a_sum[0], q_reg[WIDTH:1]};

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state    <= IDLE;
            m_reg    <= '0;
            q_reg    <= '0;
            a_reg    <= '0;
            q_1      <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mult_out <= '0;
        end else if (srst) begin
            state    <= IDLE;
            m_reg    <= '0;
            q_reg    <= '0;
            a_reg    <= '0;
            q_1      <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mult_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_ld) begin
                        m_reg <= opa_ext;
                        q_reg <= opb_ext;
                        a_reg <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    q_1   <= q_reg[0];
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        // Low 2*WIDTH bits of the post-shift {A, Q}.
                        mult_out <= {a_nxt[WIDTH-2:0], q_nxt};
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
